// File: rtl/lc3_operand_fetch.sv
// Operand fetch sequencer for the LC-3 register file.
// Reads SR1 and then SR2 over a single registered read port.
// Holds a scoreboard of pending writebacks and stalls on RAW hazards.
// Writebacks pass straight through to the write port and are never stalled.
module lc3_operand_fetch #(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_sr1,
  input  logic [2:0]  req_sr2,
  input  logic        req_use_sr2,
  input  logic [2:0]  req_dr,
  input  logic        req_dr_valid,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  op_dr,
  input  logic        wb_valid,
  input  logic [2:0]  wb_reg,
  input  logic [15:0] wb_data,
  output logic [2:0]  rf_out_reg,
  input  logic [15:0] rf_outdata,
  output logic [2:0]  rf_write_reg,
  output logic        rf_we,
  output logic [15:0] rf_indata,
  output logic [7:0]  busy_mask
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HAZ  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] RD2  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  sr1_q, sr2_q, dr_q;
  logic        use_sr2_q, dr_valid_q;
  logic [1:0]  cnt_q;
  logic        fwd_hit_q;
  logic [15:0] fwd_data_q;
  logic [7:0]  busy_d;

  logic        hazard;
  logic        rd_last;
  logic [2:0]  rd_reg;
  logic        wb_hit;
  logic [15:0] rd_value;

  // Write path: pure pass-through, active in every state including reset.
  assign rf_we        = wb_valid;
  assign rf_write_reg = wb_reg;
  assign rf_indata    = wb_data;

  assign req_ready = (state_q == IDLE) && !reset;
  assign op_valid  = (state_q == DONE);

  assign hazard   = busy_mask[sr1_q] | (use_sr2_q & busy_mask[sr2_q]);
  assign rd_last  = (cnt_q == 2'(RD_LATENCY - 1));
  assign rd_reg   = (state_q == RD2) ? sr2_q : sr1_q;
  assign wb_hit   = wb_valid && (wb_reg == rd_reg);
  // Latest writeback inside the read window overrides the stale file data.
  assign rd_value = wb_hit ? wb_data : (fwd_hit_q ? fwd_data_q : rf_outdata);

  // Next-state decode for the fetch sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = HAZ;
      HAZ:  if (!hazard) state_d = RD1;
      RD1:  if (rd_last) state_d = use_sr2_q ? RD2 : DONE;
      RD2:  if (rd_last) state_d = DONE;
      DONE: if (op_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Scoreboard update: writeback clears, operand handoff sets; set wins.
  always_comb begin
    busy_d = busy_mask;
    if (wb_valid) busy_d[wb_reg] = 1'b0;
    if ((state_q == DONE) && op_ready && dr_valid_q) busy_d[dr_q] = 1'b1;
  end

  // Request capture, read-window counting, forwarding and operand loading.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_mask  <= 8'h00;
      sr1_q      <= 3'd0;
      sr2_q      <= 3'd0;
      dr_q       <= 3'd0;
      use_sr2_q  <= 1'b0;
      dr_valid_q <= 1'b0;
      cnt_q      <= 2'd0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= 16'h0000;
      op_a       <= 16'h0000;
      op_b       <= 16'h0000;
      op_dr      <= 3'd0;
      rf_out_reg <= 3'd0;
    end else begin
      state_q   <= state_d;
      busy_mask <= busy_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            sr1_q      <= req_sr1;
            sr2_q      <= req_sr2;
            use_sr2_q  <= req_use_sr2;
            dr_q       <= req_dr;
            dr_valid_q <= req_dr_valid;
            op_dr      <= req_dr;
          end
        end
        HAZ: begin
          if (!hazard) begin
            rf_out_reg <= sr1_q;
            cnt_q      <= 2'd0;
            fwd_hit_q  <= 1'b0;
          end
        end
        RD1, RD2: begin
          if (rd_last) begin
            cnt_q     <= 2'd0;
            fwd_hit_q <= 1'b0;
            if (state_q == RD1) begin
              op_a <= rd_value;
              if (use_sr2_q) rf_out_reg <= sr2_q;
              else           op_b       <= 16'h0000;
            end else begin
              op_b <= rd_value;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
            if (wb_hit) begin
              fwd_hit_q  <= 1'b1;
              fwd_data_q <= wb_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
